// File: rtl/pc16_pkg.sv
// Shared definitions for the pc16 program counter:
// address word type, reset vector and command encoding.
package pc16_pkg;

  typedef logic [0:15] word_t;

  localparam word_t PC_RESET = 16'h0000;

  localparam logic [2:0] CMD_HOLD = 3'd0;
  localparam logic [2:0] CMD_INC  = 3'd1;
  localparam logic [2:0] CMD_LOAD = 3'd2;
  localparam logic [2:0] CMD_CALL = 3'd3;
  localparam logic [2:0] CMD_RET  = 3'd4;

endpackage

// File: rtl/pc16_gates.sv
// 16-bit datapath primitives used by the
// next-PC selection logic.
module _mux16
  import pc16_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  logic  sel,
  output word_t y
);
  assign y = sel ? b : a;
endmodule

module _inc16
  import pc16_pkg::*;
(
  input  word_t a,
  output word_t y
);
  assign y = a + 16'd1;
endmodule

// File: rtl/pc16_ret_stack.sv
// Return-address stack: synchronous push,
// combinational read of the top entry.
module ret_stack
  import pc16_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic           pop,
  input  word_t          din,
  output word_t          top,
  output logic [SPW-1:0] sp,
  output logic           full,
  output logic           empty
);

  localparam int IW = $clog2(DEPTH);

  word_t         mem [DEPTH];
  logic [IW-1:0] idx_w;
  logic [IW-1:0] idx_r;

  assign idx_w = sp[IW-1:0];
  assign idx_r = idx_w - IW'(1);
  assign top   = mem[idx_r];
  assign full  = (sp == SPW'(DEPTH));
  assign empty = (sp == '0);

  // Caller guarantees push is never raised when full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push) begin
      mem[idx_w] <= din;
      sp         <= sp + SPW'(1);
    end else if (pop) begin
      sp <= sp - SPW'(1);
    end
  end

endmodule

// File: rtl/pc16.sv
// 16-bit program counter with hardware
// return-address stack and sticky misuse flag.
module pc16
  import pc16_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic           in_clk,
  input  logic           in_rst_n,
  input  word_t          in_d,
  input  logic           in_load,
  input  logic           in_inc,
  input  logic           in_call,
  input  logic           in_ret,
  output word_t          out_pc,
  output logic [SPW-1:0] out_sp,
  output logic           out_empty,
  output logic           out_full,
  output logic           out_err
);

  logic [2:0] cmd;
  logic       push;
  logic       pop;
  word_t      pc_inc;
  word_t      top;
  word_t      m_inc;
  word_t      m_load;
  word_t      m_call;
  word_t      pc_nxt;

  always_comb begin
    cmd = CMD_HOLD;
    if (in_ret)       cmd = CMD_RET;
    else if (in_call) cmd = CMD_CALL;
    else if (in_load) cmd = CMD_LOAD;
    else if (in_inc)  cmd = CMD_INC;
  end

  assign push = (cmd == CMD_CALL) && !out_full;
  assign pop  = (cmd == CMD_RET) && !out_empty;

  _inc16 u_inc (.a(out_pc), .y(pc_inc));

  // Priority chain: later stages override earlier ones.
  _mux16 u_m_inc (
    .a(out_pc), .b(pc_inc),
    .sel(cmd == CMD_INC), .y(m_inc)
  );
  _mux16 u_m_load (
    .a(m_inc), .b(in_d),
    .sel(cmd == CMD_LOAD), .y(m_load)
  );
  _mux16 u_m_call (
    .a(m_load), .b(in_d),
    .sel(push), .y(m_call)
  );
  _mux16 u_m_ret (
    .a(m_call), .b(top),
    .sel(pop), .y(pc_nxt)
  );

  ret_stack #(
    .DEPTH(DEPTH),
    .SPW  (SPW)
  ) u_stk (
    .clk  (in_clk),
    .rst_n(in_rst_n),
    .push (push),
    .pop  (pop),
    .din  (pc_inc),
    .top  (top),
    .sp   (out_sp),
    .full (out_full),
    .empty(out_empty)
  );

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      out_pc  <= PC_RESET;
      out_err <= 1'b0;
    end else begin
      out_pc  <= pc_nxt;
      out_err <= out_err
               | ((cmd == CMD_CALL) && out_full)
               | ((cmd == CMD_RET) && out_empty);
    end
  end

endmodule

// File: tb/tb_pc16.sv
// Directed testbench for pc16: per-feature tasks
// with hand-computed expected values.
module tb_pc16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] d;
  logic        load, inc, call, ret;
  logic [15:0] pc;
  logic [3:0]  sp;
  logic        empty, full, err;

  int passed = 0;
  int total  = 0;

  pc16 dut (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .in_d     (d),
    .in_load  (load),
    .in_inc   (inc),
    .in_call  (call),
    .in_ret   (ret),
    .out_pc   (pc),
    .out_sp   (sp),
    .out_empty(empty),
    .out_full (full),
    .out_err  (err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    load = 0; inc = 0; call = 0; ret = 0;
    d = 16'h0000; rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({pc, sp, empty, full, err} !== {16'h0000, 4'd0, 3'b100})
      $display("FAIL reset: pc=%h sp=%0d e=%b f=%b err=%b want 0000 0 1 0 0",
               pc, sp, empty, full, err);
    else passed++;
  endtask

  task automatic test_inc();
    logic [15:0] exp [3] = '{16'h0001, 16'h0002, 16'h0003};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(); inc = 1; step();
      total++;
      if ({pc, empty} !== {exp[i], 1'b1})
        $display("FAIL inc%0d: pc=%h empty=%b want %h 1", i, pc, empty, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      idle();
      if (i == 0) begin load = 1; d = 16'hFFFE; end
      else inc = 1;
      step();
      total++;
      if ({pc, err} !== {exp[i], 1'b0})
        $display("FAIL wrap%0d: pc=%h err=%b want %h 0", i, pc, err, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_nested_call();
    logic [15:0] epc [4] = '{16'h0100, 16'h0200, 16'h0101, 16'h0011};
    logic [3:0]  esp [4] = '{4'd1, 4'd2, 4'd1, 4'd0};
    do_reset();
    idle(); load = 1; d = 16'h0010; step();
    for (int i = 0; i < 4; i++) begin
      idle();
      if (i == 0) begin call = 1; d = 16'h0100; end
      else if (i == 1) begin call = 1; d = 16'h0200; end
      else ret = 1;
      step();
      total++;
      if ({pc, sp} !== {epc[i], esp[i]})
        $display("FAIL nest%0d: pc=%h sp=%0d want %h %0d",
                 i, pc, sp, epc[i], esp[i]);
      else passed++;
    end
    total++;
    if ({empty, err} !== 2'b10)
      $display("FAIL nest_end: empty=%b err=%b want 1 0", empty, err);
    else passed++;
  endtask

  task automatic test_back_to_back();
    // pc is 0x0011 here; call then immediate return.
    idle(); call = 1; d = 16'h0300; step();
    idle(); ret = 1; step();
    idle(); inc = 1; step();
    total++;
    if ({pc, sp} !== {16'h0013, 4'd0})
      $display("FAIL b2b: pc=%h sp=%0d want 0013 0", pc, sp);
    else passed++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle(); call = 1; d = 16'h1000 + 16'(i); step();
    end
    total++;
    if ({pc, sp, full, empty, err} !== {16'h1007, 4'd8, 3'b100})
      $display("FAIL full: pc=%h sp=%0d f=%b e=%b err=%b want 1007 8 1 0 0",
               pc, sp, full, empty, err);
    else passed++;
    idle(); call = 1; d = 16'h0AAA; step();
    total++;
    if ({pc, sp, full, err} !== {16'h1007, 4'd8, 2'b11})
      $display("FAIL ovf: pc=%h sp=%0d f=%b err=%b want 1007 8 1 1",
               pc, sp, full, err);
    else passed++;
    idle(); ret = 1; step();
    total++;
    if ({pc, sp, full, err} !== {16'h1007, 4'd7, 2'b01})
      $display("FAIL ovf_ret: pc=%h sp=%0d f=%b err=%b want 1007 7 0 1",
               pc, sp, full, err);
    else passed++;
    idle(); ret = 1; step();
    total++;
    if ({pc, sp, err} !== {16'h1006, 4'd6, 1'b1})
      $display("FAIL ovf_ret2: pc=%h sp=%0d err=%b want 1006 6 1", pc, sp, err);
    else passed++;
  endtask

  task automatic test_underflow();
    do_reset();
    idle(); load = 1; d = 16'h0050; step();
    idle(); ret = 1; step();
    total++;
    if ({pc, sp, err} !== {16'h0050, 4'd0, 1'b1})
      $display("FAIL unf: pc=%h sp=%0d err=%b want 0050 0 1", pc, sp, err);
    else passed++;
    idle(); call = 1; ret = 1; d = 16'h0777; step();
    total++;
    if ({pc, sp, empty, err} !== {16'h0050, 4'd0, 2'b11})
      $display("FAIL unf_callret: pc=%h sp=%0d e=%b err=%b want 0050 0 1 1",
               pc, sp, empty, err);
    else passed++;
  endtask

  task automatic test_call_ret_same();
    do_reset();
    idle(); call = 1; d = 16'h0200; step();
    idle(); call = 1; ret = 1; d = 16'h0300; step();
    total++;
    if ({pc, sp, err} !== {16'h0001, 4'd0, 1'b0})
      $display("FAIL callret: pc=%h sp=%0d err=%b want 0001 0 0", pc, sp, err);
    else passed++;
  endtask

  task automatic test_priority();
    do_reset();
    idle(); load = 1; inc = 1; d = 16'h4000; step();
    total++;
    if (pc !== 16'h4000)
      $display("FAIL prio_load: pc=%h want 4000", pc);
    else passed++;
    idle(); call = 1; load = 1; inc = 1; d = 16'h5000; step();
    total++;
    if ({pc, sp} !== {16'h5000, 4'd1})
      $display("FAIL prio_call: pc=%h sp=%0d want 5000 1", pc, sp);
    else passed++;
    idle(); ret = 1; load = 1; d = 16'h6000; step();
    total++;
    if ({pc, sp} !== {16'h4001, 4'd0})
      $display("FAIL prio_ret: pc=%h sp=%0d want 4001 0", pc, sp);
    else passed++;
    idle(); step();
    total++;
    if (pc !== 16'h4001)
      $display("FAIL hold: pc=%h want 4001", pc);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    idle(); ret = 1; step();
    for (int i = 0; i < 3; i++) begin
      idle(); call = 1; d = 16'h2000 + 16'(i); step();
    end
    total++;
    if ({sp, err} !== {4'd3, 1'b1})
      $display("FAIL pre_rst: sp=%0d err=%b want 3 1", sp, err);
    else passed++;
    idle(); call = 1; d = 16'h3000; rst_n = 1'b0; step();
    total++;
    if ({pc, sp, empty, err} !== {16'h0000, 4'd0, 2'b10})
      $display("FAIL rst_mid: pc=%h sp=%0d e=%b err=%b want 0000 0 1 0",
               pc, sp, empty, err);
    else passed++;
  endtask

  initial begin
    idle();
    test_reset();
    test_inc();
    test_wrap();
    test_nested_call();
    test_back_to_back();
    test_overflow();
    test_underflow();
    test_call_ret_same();
    test_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
